// File: rtl/fir_pkg.sv
// fir_pkg: FSM state type and width helpers shared by the FIR MAC sequencer files
package fir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, HOLD} fir_seq_state_t;
  function automatic int fir_wm(input int w_x, input int w_b);
    return w_x + w_b;
  endfunction
  function automatic int fir_wy(input int w_x, input int w_b, input int n);
    return fir_wm(w_x, w_b) + n + 1;
  endfunction
endpackage

// File: rtl/fir_mac_sequencer_if.sv
// fir_mac_sequencer_if: sample-in / result-out valid-ready bundle
interface fir_mac_sequencer_if #(parameter int W_X = 8, parameter int W_Y = 22);
  logic x_valid, x_ready, y_valid, y_ready;
  logic signed [W_X-1:0] x;
  logic signed [W_Y-1:0] y;
  modport master(output x_valid, x, y_ready, input x_ready, y_valid, y);
  modport slave(input x_valid, x, y_ready, output x_ready, y_valid, y);
endinterface

// File: rtl/fir_sample_ring.sv
// fir_sample_ring: N+1 deep sample history; z_o is the sample k_i steps older than the newest
module fir_sample_ring #(
  parameter int N = 5,
  parameter int W_X = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        we_i,
  input  logic signed [W_X-1:0]       wd_i,
  input  logic [$clog2(N+1)-1:0]      k_i,
  output logic signed [W_X-1:0]       z_o
);
  localparam int W_A = $clog2(N + 1);
  logic signed [W_X-1:0] mem_q [N+1];
  logic [W_A-1:0] wp_q, wp_d;
  assign wp_d = wp_q == W_A'(N) ? '0 : wp_q + 1'b1;
  // modular wrap: the final index is below N+1, so W_A-bit overflow is harmless
  assign z_o = mem_q[wp_q >= k_i ? wp_q - k_i : wp_q + W_A'(N + 1) - k_i];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q <= '0;
      for (int i = 0; i <= N; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      wp_q <= wp_d;
      mem_q[wp_d] <= wd_i;
    end
  end
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: one shared MAC sequenced over N+1 taps per sample.
// Define FIR_SEQ_CFG_EN to make coefficients writable while idle.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int N = 5,
  parameter int W_X = 8,
  parameter int W_B = 8,
  parameter logic signed [W_B-1:0] B [N+1] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6}
) (
  input  logic                        clk,
  input  logic                        rstn,
  fir_mac_sequencer_if.slave          bus,
  input  logic                        cfg_we,
  input  logic [$clog2(N+1)-1:0]      cfg_addr,
  input  logic signed [W_B-1:0]       cfg_data,
  output logic                        busy
);
  localparam int W_M = fir_wm(W_X, W_B);
  localparam int W_Y = fir_wy(W_X, W_B, N);
  localparam int W_A = $clog2(N + 1);
  fir_seq_state_t state_q, state_d;
  logic [W_A-1:0] k_q, k_d;
  logic signed [W_Y-1:0] acc_q, acc_d;
  logic signed [W_B-1:0] coef [N+1];
  logic signed [W_X-1:0] z;
  logic signed [W_M-1:0] prod;
  logic x_hs;
  assign x_hs = state_q == IDLE && bus.x_valid;
  fir_sample_ring #(.N(N), .W_X(W_X)) u_ring (
    .clk(clk), .rstn(rstn), .we_i(x_hs), .wd_i(bus.x), .k_i(k_q), .z_o(z)
  );
`ifdef FIR_SEQ_CFG_EN
  logic signed [W_B-1:0] coef_q [N+1];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) coef_q <= B;
    else if (cfg_we && state_q == IDLE && cfg_addr <= W_A'(N)) coef_q[cfg_addr] <= cfg_data;
  end
  assign coef = coef_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_addr, cfg_data};
  assign coef = B;
`endif
  assign prod = coef[k_q] * z;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    acc_d = acc_q;
    if (x_hs) begin
      state_d = MAC;
      k_d = '0;
      acc_d = '0;
    end else if (state_q == MAC) begin
      acc_d = acc_q + W_Y'(prod);
      k_d = k_q == W_A'(N) ? '0 : k_q + 1'b1;
      state_d = k_q == W_A'(N) ? HOLD : MAC;
    end else if (state_q == HOLD && bus.y_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      k_q <= '0;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      acc_q <= acc_d;
    end
  end
  assign bus.x_ready = state_q == IDLE;
  assign bus.y_valid = state_q == HOLD;
  assign bus.y = acc_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: scoreboarded directed test of the FIR MAC sequencer (N=5, B=1..6)
module tb_fir_mac_sequencer;
  import fir_pkg::*;
`ifdef FIR_SEQ_CFG_EN
  localparam int C0 = -1;
`else
  localparam int C0 = 1;
`endif
  logic clk = 0, rstn = 0, busy;
  logic cfg_we = 0;
  logic [2:0] cfg_addr = '0;
  logic signed [7:0] cfg_data = '0;
  int total = 0, bad = 0;
  int exp_q[$];
  fir_mac_sequencer_if #(.W_X(8), .W_Y(22)) bus ();
  fir_mac_sequencer dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && bus.y_valid && bus.y_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL y_unexpected: got %0d want none", bus.y);
      end else chk("y", int'(bus.y), exp_q.pop_front());
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!bus.x_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("x_ready_wait", int'(bus.x_ready), 1);
  endtask

  task automatic send(input logic signed [7:0] v, input int e);
    wait_idle();
    bus.x = v;
    bus.x_valid = 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.x_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic signed [7:0] d);
    cfg_addr = a;
    cfg_data = d;
    cfg_we = 1;
    @(posedge clk); #1;
    cfg_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ext_n [6] = '{-109, -358, -735, -1240, -1908, -2688};
    int ext_p [6] = '{-2433, -1923, -1158, -138, 1137, 2667};
    int first, y0, n;
    logic xr_hi, stable, vhi;
    bus.x_valid = 0;
    bus.x = '0;
    bus.y_ready = 1;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    chk("rst_x_ready", int'(bus.x_ready), 1);
    chk("rst_y_valid", int'(bus.y_valid), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_busy", int'(busy), 0);
    // impulse response equals the coefficient list
    send(1, 1);
    for (int i = 2; i <= 8; i++) send(0, i <= 6 ? i : 0);
    drain();
    // idle write of coef[0]; a write during MAC must be dropped
    wait_idle();
    cfg_write(3'd0, -8'sd1);
    send(1, C0);
    cfg_write(3'd1, 8'sd7);
    for (int i = 2; i <= 7; i++) send(0, i <= 6 ? i : 0);
    drain();
    wait_idle();
    cfg_write(3'd0, 8'sd1);
    cfg_write(3'd7, 8'sd50);
    // latency: handshake at edge t, y_valid first at cycle t+7
    wait_idle();
    bus.x = 5;
    bus.x_valid = 1;
    exp_q.push_back(5);
    @(posedge clk); #1;
    bus.x_valid = 0;
    first = 0;
    xr_hi = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i <= 7 && bus.x_ready) xr_hi = 1;
      if (bus.y_valid && first == 0) first = i;
      if (i == 8) chk("x_ready_after", int'(bus.x_ready), 1);
      @(posedge clk); #1;
    end
    chk("latency", first, 7);
    chk("x_ready_low_in_flight", int'(xr_hi), 0);
    drain();
    // backpressure: result held, extra sample ignored
    bus.y_ready = 0;
    send(2, 12);
    n = 0;
    while (!bus.y_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_hold", int'(bus.y_valid), 1);
    y0 = int'(bus.y);
    stable = 1;
    bus.x = 99;
    bus.x_valid = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (int'(bus.y) != y0 || !bus.y_valid || bus.x_ready) stable = 0;
    end
    chk("bp_stable", int'(stable), 1);
    chk("bp_y", y0, 12);
    bus.x_valid = 0;
    bus.y_ready = 1;
    drain();
    // extremes
    for (int i = 0; i < 6; i++) send(-8'sd128, ext_n[i]);
    for (int i = 0; i < 6; i++) send(8'sd127, ext_p[i]);
    drain();
    // reset during MAC cycle 3 aborts the sample and restores coefficients/history
    wait_idle();
    cfg_write(3'd0, -8'sd1);
    wait_idle();
    bus.x = 3;
    bus.x_valid = 1;
    @(posedge clk); #1;
    bus.x_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", int'(busy), 1);
    rstn = 0;
    #2;
    chk("async_rst_x_ready", int'(bus.x_ready), 1);
    @(posedge clk); #1;
    rstn = 1;
    chk("post_rst_y_valid", int'(bus.y_valid), 0);
    chk("post_rst_busy", int'(busy), 0);
    vhi = 0;
    repeat (10) begin @(posedge clk); #1; if (bus.y_valid) vhi = 1; end
    chk("no_aborted_y", int'(vhi), 0);
    send(1, 1);
    for (int i = 2; i <= 8; i++) send(0, i <= 6 ? i : 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
